regfile_param_bank: RTL and testbench

Parametrised register bank for the accelerator's register interface: N configurable RW registers with byte-enable writes, live read-only status words, a sticky event/interrupt unit with mask and write-1-to-clear, and a self-clearing command register that emits one-cycle pulses. Sits behind the register-interface address decoder, one instance per address window (`BASE_ADDR`). Its `rd_hit` / `rd_data` outputs are OR-combined at the top level. Reads are registered with a valid strobe.

---
 rtl/regfile_pkg.sv | 37 +++
 rtl/regfile_evt_unit.sv | 34 +++
 rtl/regfile_param_bank.sv | 141 ++++++++++++++
 tb/tb_regfile_param_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-bank definitions: window offsets, register kinds, address decode.
package regfile_pkg;

    localparam int OFS_RO         = 'h40;
    localparam int OFS_EVT_STATUS = 'h60;
    localparam int OFS_EVT_MASK   = 'h61;
    localparam int OFS_CMD        = 'h80;
    localparam int WINDOW         = 'h100;

    typedef enum logic [2:0] {
        RW,
        RO,
        EVT_ST,
        EVT_MSK,
        CMD,
        UNMAPPED
    } reg_kind_e;

    // Classifies an in-window offset; RW and RO ranges depend on the instance sizes.
    function automatic reg_kind_e decode_ofs(input logic [7:0] ofs, input int n_rw, input int n_ro);
        int o;
        o = int'(ofs);
        if (o < n_rw && o < OFS_RO)
            return RW;
        else if (o >= OFS_RO && o < OFS_RO + n_ro && o < OFS_EVT_STATUS)
            return RO;
        else if (o == OFS_EVT_STATUS)
            return EVT_ST;
        else if (o == OFS_EVT_MASK)
            return EVT_MSK;
        else if (o == OFS_CMD)
            return CMD;
        else
            return UNMAPPED;
    endfunction

endpackage

// File: rtl/regfile_evt_unit.sv
// Sticky event status with mask and write-1-to-clear; a set in the clearing cycle wins.
// irq is registered one cycle behind status/mask.
module regfile_evt_unit #(
    parameter int N_EVT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EVT-1:0] evt_in,
    input  logic             clr_wr,
    input  logic             mask_wr,
    input  logic [N_EVT-1:0] wr_bits,
    output logic [N_EVT-1:0] status,
    output logic [N_EVT-1:0] mask,
    output logic             irq
);

    logic [N_EVT-1:0] clr_bits;

    assign clr_bits = clr_wr ? wr_bits : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
            mask   <= '0;
            irq    <= 1'b0;
        end else begin
            status <= (status & ~clr_bits) | evt_in;
            if (mask_wr)
                mask <= wr_bits;
            irq <= |(status & mask);
        end
    end

endmodule

// File: rtl/regfile_param_bank.sv
// Parametrised register window: RW registers with byte enables, RO status, events, command pulses.
// Reads return one cycle after rd_en with rd_valid; no backpressure, one access per cycle.
module regfile_param_bank #(
    parameter int                         ADDR_W    = 14,
    parameter int                         DATA_W    = 16,
    parameter logic [ADDR_W-1:0]          BASE_ADDR = '0,
    parameter int                         N_RW      = 12,
    parameter logic [N_RW*DATA_W-1:0]     RW_RESET  = '0,
    parameter int                         N_RO      = 2,
    parameter int                         N_EVT     = 2,
    parameter int                         N_CMD     = 10
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_en,
    input  logic [DATA_W/8-1:0]                       wr_strb,
    input  logic                                      rd_en,
    input  logic [ADDR_W-1:0]                         addr,
    input  logic [DATA_W-1:0]                         write_data,
    output logic [DATA_W-1:0]                         rd_data,
    output logic                                      rd_valid,
    output logic                                      rd_hit,
    output logic                                      err_pulse,
    output logic [N_RW*DATA_W-1:0]                    rw_q,
    input  logic [((N_RO > 0) ? N_RO : 1)*DATA_W-1:0] ro_d,
    input  logic [((N_EVT > 0) ? N_EVT : 1)-1:0]      evt_in,
    output logic                                      irq,
    output logic [((N_CMD > 0) ? N_CMD : 1)-1:0]      cmd_pulse
);
    import regfile_pkg::*;

    localparam int NB = DATA_W / 8;
    localparam int EW = (N_EVT > 0) ? N_EVT : 1;
    localparam int CW = (N_CMD > 0) ? N_CMD : 1;

    logic [ADDR_W-1:0] ofs_full;
    logic [7:0]        ofs;
    logic              in_win;
    reg_kind_e         kind;
    logic              wr_act;
    logic              rd_act;
    logic              wr_err;
    logic              rd_err;
    logic [DATA_W-1:0] rd_mux;
    logic              rd_mux_hit;
    logic [EW-1:0]     evt_status;
    logic [EW-1:0]     evt_mask;
    logic [DATA_W-1:0] rw_reg [N_RW];

    // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land out of window.
    assign ofs_full = addr - BASE_ADDR;
    assign in_win   = 32'(ofs_full) < 32'(WINDOW);
    assign ofs      = ofs_full[7:0];
    assign kind     = decode_ofs(ofs, N_RW, N_RO);

    assign wr_act = wr_en && in_win;
    assign rd_act = rd_en && in_win;
    assign wr_err = wr_act && (kind == UNMAPPED || kind == RO);
    assign rd_err = rd_act && (kind == UNMAPPED);

    for (genvar i = 0; i < N_RW; i++) begin : g_rw
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rw_reg[i] <= RW_RESET[i*DATA_W +: DATA_W];
            end else if (wr_act && kind == RW && ofs == 8'(i)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_strb[b])
                        rw_reg[i][b*8 +: 8] <= write_data[b*8 +: 8];
                end
            end
        end
        assign rw_q[i*DATA_W +: DATA_W] = rw_reg[i];
    end

    regfile_evt_unit #(
        .N_EVT (EW)
    ) u_evt (
        .clk     (clk),
        .rst_n   (rst_n),
        .evt_in  (evt_in),
        .clr_wr  (wr_act && kind == EVT_ST),
        .mask_wr (wr_act && kind == EVT_MSK),
        .wr_bits (write_data[EW-1:0]),
        .status  (evt_status),
        .mask    (evt_mask),
        .irq     (irq)
    );

    // Read mux sees pre-write state, so a same-cycle read/write returns the old value.
    always_comb begin
        rd_mux     = '0;
        rd_mux_hit = 1'b0;
        case (kind)
            RW: begin
                rd_mux_hit = 1'b1;
                for (int i = 0; i < N_RW; i++) begin
                    if (ofs == 8'(i))
                        rd_mux = rw_reg[i];
                end
            end
            RO: begin
                rd_mux_hit = 1'b1;
                for (int i = 0; i < N_RO; i++) begin
                    if (ofs == 8'(OFS_RO + i))
                        rd_mux = ro_d[i*DATA_W +: DATA_W];
                end
            end
            EVT_ST: begin
                rd_mux_hit = 1'b1;
                rd_mux     = DATA_W'(evt_status);
            end
            EVT_MSK: begin
                rd_mux_hit = 1'b1;
                rd_mux     = DATA_W'(evt_mask);
            end
            CMD: begin
                rd_mux_hit = 1'b1;
            end
            default: begin
                rd_mux_hit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_hit    <= 1'b0;
            err_pulse <= 1'b0;
            cmd_pulse <= '0;
        end else begin
            rd_valid  <= rd_act;
            rd_data   <= rd_act ? rd_mux : '0;
            rd_hit    <= rd_act && rd_mux_hit;
            err_pulse <= wr_err || rd_err;
            cmd_pulse <= (wr_act && kind == CMD && N_CMD > 0) ? write_data[CW-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_regfile_param_bank.sv
// Bench for regfile_param_bank: read responses checked by a scoreboard monitor,
// side-band outputs (rw_q, irq, cmd_pulse, err_pulse) checked directly after each edge.
module tb_regfile_param_bank;

    localparam logic [12*16-1:0] RST = (192'h0008 << 48) | (192'h1234 << 32);

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [1:0]   wr_strb;
    logic         rd_en;
    logic [13:0]  addr;
    logic [15:0]  write_data;
    logic [15:0]  rd_data;
    logic         rd_valid;
    logic         rd_hit;
    logic         err_pulse;
    logic [191:0] rw_q;
    logic [31:0]  ro_d;
    logic [1:0]   evt_in;
    logic         irq;
    logic [9:0]   cmd_pulse;

    int errors = 0;
    int checks = 0;
    logic [16:0] sb_q [$];

    regfile_param_bank #(
        .ADDR_W    (14),
        .DATA_W    (16),
        .BASE_ADDR (14'h0),
        .N_RW      (12),
        .RW_RESET  (RST),
        .N_RO      (2),
        .N_EVT     (2),
        .N_CMD     (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_strb    (wr_strb),
        .rd_en      (rd_en),
        .addr       (addr),
        .write_data (write_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_hit     (rd_hit),
        .err_pulse  (err_pulse),
        .rw_q       (rw_q),
        .ro_d       (ro_d),
        .evt_in     (evt_in),
        .irq        (irq),
        .cmd_pulse  (cmd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] s);
        wr_en      = 1'b1;
        addr       = a;
        write_data = d;
        wr_strb    = s;
        cyc();
        wr_en      = 1'b0;
    endtask

    task automatic do_rd(input logic [13:0] a, input logic [15:0] exp_d, input logic exp_h);
        rd_en = 1'b1;
        addr  = a;
        sb_q.push_back({exp_h, exp_d});
        cyc();
        rd_en = 1'b0;
    endtask

    // Monitor: every response pops one expectation; idle cycles must show zero data/hit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    logic [16:0] e;
                    e = sb_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e[15:0]));
                    chk("rd_hit", 32'(rd_hit), 32'(e[16]));
                end
            end else begin
                chk("idle_rd_data_hit", {15'd0, rd_hit, rd_data}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wr_strb    = 2'b00;
        addr       = '0;
        write_data = '0;
        ro_d       = {16'hC3C3, 16'h5A5A};
        evt_in     = 2'b00;
        #12;
        chk("reset_outputs", {rd_valid, rd_hit, err_pulse, irq, 2'b00, cmd_pulse, rd_data}, 32'd0);
        chk("reset_rw_q", 32'(rw_q == RST), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset value and full write
        do_rd(14'h003, 16'h0008, 1'b1);
        do_wr(14'h003, 16'hABCD, 2'b11);
        chk("rw_q3_full", 32'(rw_q[3*16 +: 16]), 32'h0000ABCD);
        do_rd(14'h003, 16'hABCD, 1'b1);

        // Byte-enable writes
        do_wr(14'h002, 16'hFFFF, 2'b10);
        chk("rw_q2_byte", 32'(rw_q[2*16 +: 16]), 32'h0000FF34);
        do_rd(14'h002, 16'hFF34, 1'b1);
        do_wr(14'h002, 16'h0000, 2'b00);
        chk("zero_strb_no_err", 32'(err_pulse), 32'd0);
        chk("zero_strb_no_change", 32'(rw_q[2*16 +: 16]), 32'h0000FF34);
        do_wr(14'h002, 16'h5600, 2'b01);
        chk("rw_q2_low", 32'(rw_q[2*16 +: 16]), 32'h0000FF00);

        // Events and interrupt
        evt_in = 2'b01;
        cyc();
        evt_in = 2'b00;
        do_rd(14'h060, 16'h0001, 1'b1);
        chk("irq_masked", 32'(irq), 32'd0);
        do_wr(14'h061, 16'h0001, 2'b00);
        chk("irq_mask_edge", 32'(irq), 32'd0);
        cyc();
        chk("irq_after_mask", 32'(irq), 32'd1);
        do_rd(14'h061, 16'h0001, 1'b1);
        evt_in = 2'b01;
        do_wr(14'h060, 16'h0001, 2'b11);
        evt_in = 2'b00;
        do_rd(14'h060, 16'h0001, 1'b1);
        chk("irq_set_wins", 32'(irq), 32'd1);
        do_wr(14'h060, 16'h0001, 2'b00);
        cyc();
        chk("irq_after_clear", 32'(irq), 32'd0);
        do_rd(14'h060, 16'h0000, 1'b1);
        evt_in = 2'b10;
        cyc();
        evt_in = 2'b00;
        cyc();
        chk("irq_unmasked_bit", 32'(irq), 32'd0);
        do_rd(14'h060, 16'h0002, 1'b1);
        do_wr(14'h060, 16'hFFFF, 2'b11);
        do_rd(14'h060, 16'h0000, 1'b1);

        // Command pulses, back to back
        do_wr(14'h080, 16'h0201, 2'b11);
        chk("cmd_pulse_1", 32'(cmd_pulse), 32'h201);
        do_wr(14'h080, 16'h0201, 2'b11);
        chk("cmd_pulse_2", 32'(cmd_pulse), 32'h201);
        cyc();
        chk("cmd_pulse_end", 32'(cmd_pulse), 32'h0);
        do_rd(14'h080, 16'h0000, 1'b1);

        // Errors and hit flags
        do_wr(14'h040, 16'hFFFF, 2'b11);
        chk("ro_wr_err", 32'(err_pulse), 32'd1);
        cyc();
        chk("ro_wr_err_end", 32'(err_pulse), 32'd0);
        do_rd(14'h040, 16'h5A5A, 1'b1);
        do_rd(14'h041, 16'hC3C3, 1'b1);
        do_rd(14'h020, 16'h0000, 1'b0);
        chk("unmapped_rd_err", 32'(err_pulse), 32'd1);
        do_rd(14'h00C, 16'h0000, 1'b0);
        do_rd(14'h042, 16'h0000, 1'b0);
        cyc();
        rd_en = 1'b1;
        addr  = 14'h100;
        cyc();
        rd_en = 1'b0;
        chk("out_of_window_valid", 32'(rd_valid), 32'd0);
        chk("out_of_window_err", 32'(err_pulse), 32'd0);
        do_wr(14'h3FFF, 16'hFFFF, 2'b11);
        chk("below_base_err", 32'(err_pulse), 32'd0);

        // Simultaneous read and write
        wr_en = 1'b1; rd_en = 1'b1; addr = 14'h005; write_data = 16'h1111; wr_strb = 2'b11;
        sb_q.push_back({1'b1, 16'h0000});
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        do_rd(14'h005, 16'h1111, 1'b1);
        wr_en = 1'b1; rd_en = 1'b1; addr = 14'h030;
        sb_q.push_back({1'b0, 16'h0000});
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rdwr_err_once", 32'(err_pulse), 32'd1);
        cyc();
        chk("rdwr_err_end", 32'(err_pulse), 32'd0);

        // Reset mid-operation
        evt_in = 2'b01;
        cyc();
        evt_in = 2'b00;
        cyc();
        chk("irq_before_reset", 32'(irq), 32'd1);
        wr_en = 1'b1; rd_en = 1'b1; addr = 14'h080; write_data = 16'h0201; wr_strb = 2'b11;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("cmd_before_reset", 32'(cmd_pulse), 32'h201);
        chk("valid_before_reset", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {rd_valid, irq, cmd_pulse}, 32'd0);
        chk("async_reset_rw_q", 32'(rw_q == RST), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        do_rd(14'h060, 16'h0000, 1'b1);
        do_rd(14'h061, 16'h0000, 1'b1);
        do_rd(14'h003, 16'h0008, 1'b1);
        do_rd(14'h005, 16'h0000, 1'b1);
        cyc();
        cyc();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
